branch_cmp_ctrl: RTL
====================

// Module: branch_cmp_ctrl
// PURPOSE
// - Sequences the ID-stage N-bit equality comparator for BEQ/BNE resolution.
// - Waits for hazard-free operands, registers them onto the comparator inputs, samples the equal flag and issues a one-cycle redirect/flush.
// - Stalls the front end while a branch is in flight; sits between the ID-stage decode/hazard logic and the PC-select mux.
// PARAMETERS
// - BITS      32  operand, comparator and PC width
// - WAIT_MAX  15  max operand-wait cycles before wait_err_o fires; sizes wait counter (>=1)
// PORTS
// - clk            in   1     clock, rising edge
// - rst_n          in   1     async active-low reset
// - br_valid_i     in   1     ID holds a conditional branch
// - br_ne_i        in   1     0=BEQ, 1=BNE; sampled with operands
// - rs1_data_i     in   BITS  operand A (post-forwarding)
// - rs2_data_i     in   BITS  operand B (post-forwarding)
// - ops_ready_i    in   1     both operands hazard-free this cycle
// - br_target_i    in   BITS  branch target PC; sampled with operands
// - flush_i        in   1     younger-instruction kill from a later stage
// - cmp_a_o        out  BITS  registered comparator input Data0
// - cmp_b_o        out  BITS  registered comparator input Data1
// - cmp_eq_i       in   1     comparator Out (combinational from cmp_a_o/cmp_b_o)
// - stall_o        out  1     hold PC and IF/ID
// - redirect_o     out  1     one-cycle pulse: branch taken
// - redirect_pc_o  out  BITS  target; valid while redirect_o=1
// - flush_id_o     out  1     one-cycle pulse with redirect_o: squash IF/ID
// - wait_err_o     out  1     sticky: operand wait reached WAIT_MAX
// BEHAVIOUR
// - Reset: state=IDLE; cmp_a_o, cmp_b_o, redirect_pc_o = 0; all 1-bit outputs = 0; wait counter = 0.
// - States: IDLE, WAIT, CMP, RESOLVE (2-bit encoded).
// - IDLE: br_valid_i & ops_ready_i -> CMP (latch rs1/rs2 to cmp_a_o/cmp_b_o, latch br_ne_i and br_target_i);
//   br_valid_i & !ops_ready_i -> WAIT (counter cleared); otherwise stay.
// - WAIT: counter +1 per cycle, saturates at WAIT_MAX; when it equals WAIT_MAX, set wait_err_o.
//   ops_ready_i -> CMP (latch as above); !br_valid_i -> IDLE (branch withdrawn, no outputs).
// - CMP: taken = cmp_eq_i ^ br_ne_q, registered; unconditionally -> RESOLVE.
// - RESOLVE: redirect_o = flush_id_o = taken; redirect_pc_o = latched target; stall_o = 0; -> IDLE.
//   Outputs are registered: they are valid in RESOLVE and clear the next cycle.
// - stall_o = (state==WAIT) | (state==CMP) | (state==IDLE & br_valid_i). The IDLE term is combinational so stall applies in the branch's first cycle.
// - Latency: with operands ready in cycle T, redirect_o is high in cycle T+2. Each cycle in WAIT adds 1.
// - Back-to-back: the branch leaves ID in RESOLVE. A new br_valid_i is not accepted in RESOLVE; it is taken from IDLE on the next cycle.
// - flush_i has priority in every state: the next state is IDLE, and redirect_o/flush_id_o are forced to 0 that cycle and the next.
//   Latched operands are left unchanged. The counter clears.
// - A flush in RESOLVE suppresses the pulse in that same cycle (combinational gating).
// - wait_err_o clears only on reset.
// - Async reset mid-branch: everything returns to reset values immediately; no partial redirect.
// CONFIGURATION
// - BRCTRL_STATS_EN defined: adds outputs taken_cnt_o[15:0] and not_taken_cnt_o[15:0].
//   They count resolved branches at RESOLVE (flushed ones are excluded), saturate at 16'hFFFF, and reset to 0.
// - Not defined: these ports and counters are absent; all other behaviour is identical.
// TESTING
// - BEQ with rs1=rs2=32'h1234_5678, ready at T -> stall_o T..T+1; redirect_o=1 and redirect_pc_o=br_target_i at T+2 only.
// - BNE with rs1=5, rs2=5, ready -> redirect_o and flush_id_o stay 0; stall drops at T+2; IDLE at T+3.
// - BEQ with rs1=0, rs2=1 and ops_ready_i low 3 cycles -> WAIT 3 cycles; cmp_a_o=0, cmp_b_o=1 latched on ready; no redirect; stall held throughout.
// - WAIT_MAX=4, ops_ready_i low 6 cycles -> wait_err_o rises on the 4th WAIT cycle and stays high after completion.
// - flush_i in CMP for a taken BEQ -> IDLE next cycle; redirect_o never asserts. Repeat in RESOLVE -> pulse suppressed.
// - Two consecutive taken BEQs (second held valid) -> two redirect pulses 3 cycles apart. With BRCTRL_STATS_EN, taken_cnt_o=2 and not_taken_cnt_o=0.

Source files
------------

// File: rtl/branch_cmp_ctrl.sv
// ID-stage BEQ/BNE resolution controller: registers operands onto the equality comparator and issues a one-cycle redirect/flush.
// Optional build macro BRCTRL_STATS_EN adds saturating taken/not-taken resolution counters.
module branch_cmp_ctrl #(
  parameter int BITS     = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid_i,
  input  logic            br_ne_i,
  input  logic [BITS-1:0] rs1_data_i,
  input  logic [BITS-1:0] rs2_data_i,
  input  logic            ops_ready_i,
  input  logic [BITS-1:0] br_target_i,
  input  logic            flush_i,
  output logic [BITS-1:0] cmp_a_o,
  output logic [BITS-1:0] cmp_b_o,
  input  logic            cmp_eq_i,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [BITS-1:0] redirect_pc_o,
  output logic            flush_id_o,
`ifdef BRCTRL_STATS_EN
  output logic [15:0]     taken_cnt_o,
  output logic [15:0]     not_taken_cnt_o,
`endif
  output logic            wait_err_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CMP     = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_wait_cnt;
  logic [BITS-1:0] r_cmp_a;
  logic [BITS-1:0] r_cmp_b;
  logic [BITS-1:0] r_target;
  logic [BITS-1:0] r_redirect_pc;
  logic            r_ne;
  logic            r_taken;
  logic            r_wait_err;

  logic            w_latch;
  logic [CW-1:0]   w_cnt_inc;

  // Operands are captured the cycle the branch is seen with hazard-free data, unless killed.
  assign w_latch   = !flush_i && ops_ready_i &&
                     (((r_state == IDLE) && br_valid_i) || (r_state == WAIT));
  assign w_cnt_inc = (r_wait_cnt == MAX_CNT) ? MAX_CNT : r_wait_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_cmp_a       <= '0;
      r_cmp_b       <= '0;
      r_target      <= '0;
      r_redirect_pc <= '0;
      r_ne          <= 1'b0;
      r_taken       <= 1'b0;
      r_wait_err    <= 1'b0;
    end else begin
      r_taken       <= 1'b0;
      r_redirect_pc <= '0;
      if (w_latch) begin
        r_cmp_a  <= rs1_data_i;
        r_cmp_b  <= rs2_data_i;
        r_ne     <= br_ne_i;
        r_target <= br_target_i;
      end
      if (flush_i) begin
        r_state    <= IDLE;
        r_wait_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (br_valid_i) begin
              if (ops_ready_i) begin
                r_state <= CMP;
              end else begin
                r_state    <= WAIT;
                r_wait_cnt <= '0;
              end
            end
          end
          WAIT: begin
            r_wait_cnt <= w_cnt_inc;
            if (w_cnt_inc == MAX_CNT) r_wait_err <= 1'b1;
            if (ops_ready_i)      r_state <= CMP;
            else if (!br_valid_i) r_state <= IDLE;
          end
          CMP: begin
            r_taken       <= cmp_eq_i ^ r_ne;
            r_redirect_pc <= r_target;
            r_state       <= RESOLVE;
          end
          RESOLVE: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef BRCTRL_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_not_taken_cnt;

  // Only branches that complete RESOLVE without a kill are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt     <= '0;
      r_not_taken_cnt <= '0;
    end else if ((r_state == RESOLVE) && !flush_i) begin
      if (r_taken) begin
        if (r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'd1;
      end else begin
        if (r_not_taken_cnt != 16'hFFFF) r_not_taken_cnt <= r_not_taken_cnt + 16'd1;
      end
    end
  end

  assign taken_cnt_o     = r_taken_cnt;
  assign not_taken_cnt_o = r_not_taken_cnt;
`endif

  assign cmp_a_o       = r_cmp_a;
  assign cmp_b_o       = r_cmp_b;
  assign redirect_pc_o = r_redirect_pc;
  assign wait_err_o    = r_wait_err;
  // A late kill must squash the pulse in the very cycle it is presented.
  assign redirect_o    = r_taken && !flush_i;
  assign flush_id_o    = r_taken && !flush_i;
  assign stall_o       = (r_state == WAIT) || (r_state == CMP) ||
                         ((r_state == IDLE) && br_valid_i);

endmodule
